// File: rtl/inst_beat_packer.sv
// inst_beat_packer
//   Assembles IN_W-bit DRAM read beats into OUT_W-bit instruction words for
//   the instruction queue enqueue port. Beat k of a word lands in slot k
//   (little-endian by beat). A burst end before the word is full zero-pads it.
//   A flush discards any partially filled word.
//
// Ports
//   clock           sole clock, rising edge
//   reset           asynchronous reset, active low
//   io_flush        discard partially assembled word
//   io_in_valid     beat valid
//   io_in_ready     beat accepted this cycle
//   io_in_bits      read-data beat
//   io_in_last      beat is last of its burst
//   io_out_valid    assembled word valid (queue enq_valid)
//   io_out_ready    queue enq_ready
//   io_out_bits     assembled word (queue enq_bits)
//   io_out_partial  current word was zero-padded by a burst end
//   io_busy         partial fill in progress or word pending
//   io_word_count   [INST_BEAT_PACKER_PERF_EN] words delivered, wraps
//   io_pad_count    [INST_BEAT_PACKER_PERF_EN] padded words delivered, saturates
//
// Optional feature macro: INST_BEAT_PACKER_PERF_EN
//
// state | meaning
// EMPTY | cnt_q == 0, full_q == 0: no beats held
// FILL  | cnt_q != 0, full_q == 0: word partially assembled
// FULL  | full_q == 1: word presented on the output, cnt_q == 0
module inst_beat_packer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_flush,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [IN_W-1:0]  io_in_bits,
  input  logic             io_in_last,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [OUT_W-1:0] io_out_bits,
  output logic             io_out_partial,
  output logic             io_busy
`ifdef INST_BEAT_PACKER_PERF_EN
  ,
  output logic [31:0]      io_word_count,
  output logic [15:0]      io_pad_count
`endif
);

  localparam int RATIO = OUT_W / IN_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

  logic [OUT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             partial_q, partial_d;

  logic in_fire;
  logic out_fire;

  assign io_in_ready = reset & ~io_flush & (~full_q | io_out_ready);
  assign in_fire     = io_in_valid & io_in_ready;
  assign out_fire    = full_q & io_out_ready;

  always_comb begin
    word_d    = word_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    partial_d = partial_q;

    if (out_fire) begin
      full_d    = 1'b0;
      partial_d = 1'b0;
    end

    // A held FULL word survives a flush; only an unheld buffer is cleared.
    if (io_flush) begin
      cnt_d = '0;
      if (!full_q || out_fire) begin
        word_d = '0;
      end
    end

    if (in_fire) begin
      // Writing slot 0 clears every higher slot so a short word is zero-padded.
      for (int k = 0; k < RATIO; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          word_d[k*IN_W +: IN_W] = io_in_bits;
        end else if (cnt_q == '0) begin
          word_d[k*IN_W +: IN_W] = '0;
        end
      end

      if (io_in_last || cnt_q == LAST_SLOT) begin
        full_d    = 1'b1;
        partial_d = (cnt_q != LAST_SLOT);
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_q    <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      partial_q <= partial_d;
    end
  end

  assign io_out_valid   = full_q;
  assign io_out_bits    = word_q;
  assign io_out_partial = partial_q;
  assign io_busy        = full_q | (cnt_q != '0);

`ifdef INST_BEAT_PACKER_PERF_EN
  logic [31:0] word_count_q, word_count_d;
  logic [15:0] pad_count_q, pad_count_d;

  always_comb begin
    word_count_d = word_count_q;
    pad_count_d  = pad_count_q;
    if (out_fire) begin
      word_count_d = word_count_q + 32'd1;
      if (partial_q && pad_count_q != 16'hFFFF) begin
        pad_count_d = pad_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_count_q <= '0;
      pad_count_q  <= '0;
    end else begin
      word_count_q <= word_count_d;
      pad_count_q  <= pad_count_d;
    end
  end

  assign io_word_count = word_count_q;
  assign io_pad_count  = pad_count_q;
`endif

endmodule

// File: tb/tb_inst_beat_packer.sv
module tb_inst_beat_packer;

  localparam int IN_W  = 64;
  localparam int OUT_W = 128;
  localparam int RATIO = OUT_W / IN_W;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             io_flush = 1'b0;
  logic             io_in_valid = 1'b0;
  logic             io_in_ready;
  logic [IN_W-1:0]  io_in_bits = '0;
  logic             io_in_last = 1'b0;
  logic             io_out_valid;
  logic             io_out_ready = 1'b0;
  logic [OUT_W-1:0] io_out_bits;
  logic             io_out_partial;
  logic             io_busy;
`ifdef INST_BEAT_PACKER_PERF_EN
  logic [31:0]      io_word_count;
  logic [15:0]      io_pad_count;
`endif

  inst_beat_packer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_flush       (io_flush),
    .io_in_valid    (io_in_valid),
    .io_in_ready    (io_in_ready),
    .io_in_bits     (io_in_bits),
    .io_in_last     (io_in_last),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_bits    (io_out_bits),
    .io_out_partial (io_out_partial),
    .io_busy        (io_busy)
`ifdef INST_BEAT_PACKER_PERF_EN
    ,
    .io_word_count  (io_word_count),
    .io_pad_count   (io_pad_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [OUT_W-1:0] word;
    logic             partial;
  } exp_t;

  int errors = 0;
  int checks = 0;

  // Reference model: beats held for the word under construction, the queue
  // of completed words not yet delivered, and whether a word is pending.
  logic [IN_W-1:0] cur[$];
  exp_t            sb[$];
  bit              m_full = 1'b0;
  bit              m_full_partial = 1'b0;
  int unsigned     m_words = 0;
  int unsigned     m_pads = 0;

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t build_word();
    exp_t e;
    e.word = '0;
    for (int i = 0; i < cur.size(); i++) e.word[i*IN_W +: IN_W] = cur[i];
    e.partial = (cur.size() < RATIO);
    return e;
  endfunction

  // Model update at each edge, from the values the bench itself drove.
  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        cur.delete();
        sb.delete();
        m_full = 1'b0;
        m_full_partial = 1'b0;
        m_words = 0;
        m_pads = 0;
      end else begin
        bit accept;
        bit ofire;
        ofire  = m_full && io_out_ready;
        accept = io_in_valid && !io_flush && (!m_full || io_out_ready);
        if (ofire) begin
          m_full = 1'b0;
          m_words++;
          if (m_full_partial && m_pads < 16'hFFFF) m_pads++;
        end
        if (io_flush) cur.delete();
        if (accept) begin
          cur.push_back(io_in_bits);
          if (io_in_last || cur.size() == RATIO) begin
            exp_t e;
            e = build_word();
            sb.push_back(e);
            m_full = 1'b1;
            m_full_partial = e.partial;
            cur.delete();
          end
        end
      end
    end
  end

  // Monitor: compares the presented word with the oldest expected one.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("in_ready", io_in_ready, !io_flush && (!m_full || io_out_ready));
        check("busy", io_busy, m_full || cur.size() != 0);
        check("out_valid", io_out_valid, sb.size() != 0);
`ifdef INST_BEAT_PACKER_PERF_EN
        check("word_count", io_word_count, m_words);
        check("pad_count", io_pad_count, m_pads);
`endif
        if (io_out_valid && sb.size() != 0) begin
          check("out_bits", io_out_bits, sb[0].word);
          check("out_partial", io_out_partial, sb[0].partial);
          if (io_out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [IN_W-1:0] d, input bit l, input bit f, input bit r);
    @(posedge clock);
    #1;
    io_in_valid  = v;
    io_in_bits   = d;
    io_in_last   = l;
    io_flush     = f;
    io_out_ready = r;
  endtask

  task automatic idle(input bit r);
    drive(1'b0, '0, 1'b0, 1'b0, r);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", io_out_valid, 1'b0);
    check("rst_out_bits", io_out_bits, '0);
    check("rst_out_partial", io_out_partial, 1'b0);
    check("rst_busy", io_busy, 1'b0);
    check("rst_in_ready", io_in_ready, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Basic pack
    drive(1, 64'h1111_1111_1111_1111, 0, 0, 1);
    drive(1, 64'h2222_2222_2222_2222, 1, 0, 1);
    idle(1);
    #1 check("basic_word", io_out_bits, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    idle(1);

    // Backpressure, then release with a beat waiting
    drive(1, 64'h1111_1111_1111_1111, 0, 0, 1);
    drive(1, 64'h2222_2222_2222_2222, 1, 0, 0);
    for (int i = 0; i < 10; i++) idle(0);
    drive(1, 64'h3333_3333_3333_3333, 1, 0, 1);
    idle(1);
    idle(1);

    // Short burst
    drive(1, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 1);
    idle(1);
    #1 check("short_word", io_out_bits, {64'h0, 64'hAAAA_BBBB_CCCC_DDDD});
    check("short_partial", io_out_partial, 1'b1);
    idle(1);

    // Streaming
    for (int i = 0; i < 8; i++) drive(1, {8{8'(i + 1)}}, 0, 0, 1);
    idle(1);
    idle(1);

    // Flush
    drive(1, 64'h5555_5555_5555_5555, 0, 0, 1);
    drive(1, 64'h6666_6666_6666_6666, 0, 1, 1);
    drive(1, 64'h7777_7777_7777_7777, 0, 0, 1);
    drive(1, 64'h8888_8888_8888_8888, 0, 0, 1);
    idle(1);
    idle(1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    // Drain pending word with a bounded wait
    begin
      int n = 0;
      idle(1);
      while (sb.size() != 0 && n < 20) begin
        idle(1);
        n++;
      end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
      end
    end

    // Async reset mid-word
    drive(1, 64'h1234_5678_9ABC_DEF0, 0, 0, 0);
    drive(1, 64'h0FED_CBA9_8765_4321, 0, 0, 0);
    idle(0);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("arst_out_valid", io_out_valid, 1'b0);
    check("arst_busy", io_busy, 1'b0);
    check("arst_out_bits", io_out_bits, '0);
`ifdef INST_BEAT_PACKER_PERF_EN
    check("arst_word_count", io_word_count, '0);
`endif
    @(posedge clock);
    #1 reset = 1'b1;
    drive(1, 64'hCAFE_0000_0000_0001, 1, 0, 1);
    idle(1);
    idle(1);
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_beat_packer.md
Name: inst_beat_packer

Overview:
- Upstream stage of the 128-bit instruction SyncQueue in the VTA fetch path.
- Collects narrow DRAM read-data beats (64 bits each) and assembles them into full instruction words (128 bits).
- Presents each word on a ready/valid enqueue interface that connects directly to the queue's enq port.
- Zero-pads an instruction cut short by a burst end, and supports flushing a partial word.

Parameters:
- IN_W, 64, read-data beat width in bits.
- OUT_W, 128, instruction word width in bits. Must be an integer multiple of IN_W.
- RATIO, OUT_W/IN_W (derived, 2 by default), beats per word. Must be ≥ 2.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- io_flush  input  1  discard partially assembled word.
- io_in_valid  input  1  beat valid.
- io_in_ready  output  1  packer accepts beat this cycle.
- io_in_bits  input  IN_W  read-data beat.
- io_in_last  input  1  beat is last of its burst.
- io_out_valid  output  1  assembled word valid; drives queue enq_valid.
- io_out_ready  input  1  from queue enq_ready.
- io_out_bits  output  OUT_W  assembled word; drives queue enq_bits.
- io_out_partial  output  1  current word was zero-padded by io_in_last.
- io_busy  output  1  partial fill in progress or word pending.

Behaviour:
- State: word buffer buf[OUT_W-1:0], beat counter cnt (0..RATIO-1), full flag, partial flag.
- Reset (reset=0, async): buf=0, cnt=0, full=0, partial=0.
  - Hence io_out_valid=0, io_out_bits=0, io_out_partial=0, io_busy=0.
  - io_in_ready is 0 while reset is asserted.
- Logical states:
  - EMPTY: cnt=0, full=0.
  - FILL: cnt>0, full=0.
  - FULL: full=1.
- Transitions:
  - EMPTY→FILL on an accepted beat.
  - FILL→FULL on the RATIO-th beat, or on any beat with io_in_last.
  - FULL→EMPTY on output fire without a simultaneous accept.
  - FULL→FILL on output fire with a simultaneous accept.
- Packing is little-endian by beat:
  - beat k (0-based) lands in buf[(k+1)*IN_W-1 : k*IN_W].
  - Beat fire = io_in_valid & io_in_ready.
- Slot 0 write: when a beat is written into slot 0, all higher slots are cleared the same cycle, so stale data never leaks.
- io_in_last on beat k < RATIO-1:
  - word completes with slots above k zero (from the clear above);
  - full=1, partial=1, cnt returns to 0.
- io_in_last on beat RATIO-1: normal completion, partial=0.
- io_in_ready = !io_flush & (!full | io_out_ready).
  - Pass-through: while FULL with io_out_ready=1, a new beat is accepted the same cycle and lands in slot 0 of the next word.
  - Sustained throughput is one beat per cycle with zero bubbles.
- Output fire = io_out_valid & io_out_ready.
  - Clears full and partial unless a word completes in the same cycle.
  - That case arises only when RATIO beats have been compressed by last, i.e. a single beat with last while passing through; full then stays 1 and partial takes the new value.
- io_out_valid = full.
  - io_out_bits and io_out_partial are stable while io_out_valid=1 and io_out_ready=0. Handshake rule: no change before fire.
- Latency: word valid the cycle after its final beat fires.
- io_flush:
  - Synchronous. Sets cnt=0 and clears buf slots of the partial word.
  - Does NOT drop a pending FULL word; that word still waits for io_out_ready.
  - Beats are refused during flush (io_in_ready=0).
- io_busy = full | (cnt != 0).
- io_in_last with io_in_valid=0 is ignored.
- Reset asserted mid-word: the partial word is lost with no output; a held FULL word is also lost.

Optional Feature:
- Macro: INST_BEAT_PACKER_PERF_EN.
- Defined:
  - Adds output io_word_count [31:0]: increments on every output fire, wraps at 2^32, reset to 0.
  - Adds output io_pad_count [15:0]: increments on output fire with io_out_partial=1, saturates at 0xFFFF, reset to 0.
- Undefined: neither port nor its counter exists; all other behaviour is identical.

Test Plan:
- Basic pack: beats 0x1111_1111_1111_1111 then 0x2222_2222_2222_2222 (last on 2nd), io_out_ready=1 → one cycle later io_out_valid=1, io_out_bits=0x2222222222222222_1111111111111111, io_out_partial=0.
- Backpressure: hold io_out_ready=0 after a word completes → io_in_ready=0, io_out_bits stable for 10 cycles. Then raise io_out_ready with a beat valid → word fires and the new beat is accepted the same cycle.
- Short burst: single beat 0xAAAA_BBBB_CCCC_DDDD with io_in_last=1 → io_out_bits=0x0000000000000000_AAAABBBBCCCCDDDD, io_out_partial=1.
- Streaming: 8 back-to-back beats, io_out_ready=1 throughout → io_in_ready never drops; 4 words emitted on consecutive alternate cycles, in order.
- Flush: one beat 0x5555…, then io_flush=1, then beats 0x7777…, 0x8888… → output 0x8888…_7777…; 0x5555… never appears; io_busy=0 after the flush cycle.
- Async reset: assert reset=0 mid-word, between clock edges → io_out_valid, io_busy and io_out_bits go to 0 immediately. With INST_BEAT_PACKER_PERF_EN defined, io_word_count also reads 0.
